// File: rtl/alu_cmd_sequencer.sv
// Front-end controller for the 4-bit ALU: debounces four push buttons into one-shot
// commands, sequences operand/select loading and execution, and captures ALU results.
module alu_cmd_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ALU_LATENCY     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push1,
  input  logic       push2,
  input  logic       push3,
  input  logic       push4,
  input  logic [3:0] no,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [3:0] alu_res,
  input  logic [3:0] alu_flags,
  output logic [3:0] res,
  output logic [3:0] flags,
  output logic [2:0] loaded,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int WAIT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ALU_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  logic [3:0] raw_s;
  logic [3:0] event_s;

  assign raw_s = {push4, push3, push2, push1};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic             s1_r;
    logic             s2_r;
    logic             lvl_r;
    logic             ev_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise the raw button, debounce it, and pulse once on each accepted rising level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_r  <= 1'b0;
        s2_r  <= 1'b0;
        lvl_r <= 1'b0;
        ev_r  <= 1'b0;
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        s1_r <= raw_s[i];
        s2_r <= s1_r;
        ev_r <= 1'b0;
        if (s2_r != lvl_r) begin
          if (cnt_r == CNT_LAST) begin
            lvl_r <= s2_r;
            cnt_r <= {CNT_W{1'b0}};
            ev_r  <= s2_r;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_r <= {CNT_W{1'b0}};
        end
      end
    end

    assign event_s[i] = ev_r;
  end

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [3:0]        a_r;
  logic [3:0]        b_r;
  logic [1:0]        sel_r;
  logic [3:0]        res_r;
  logic [3:0]        flags_r;
  logic [2:0]        loaded_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              ld_a_s;
  logic              ld_b_s;
  logic              ld_sel_s;
  logic              err_s;
  logic              cap_s;
  logic              wait_clr_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (event_s[3] && (loaded_r == 3'b111)) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = ST_CAPTURE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_CAPTURE: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Command decode; execute outranks the loads, and only one event acts per cycle.
  always_comb begin
    ld_a_s     = 1'b0;
    ld_b_s     = 1'b0;
    ld_sel_s   = 1'b0;
    err_s      = 1'b0;
    cap_s      = 1'b0;
    wait_clr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (event_s[3]) begin
          err_s = (loaded_r != 3'b111);
        end else if (event_s[0]) begin
          ld_a_s = 1'b1;
        end else if (event_s[1]) begin
          ld_b_s = 1'b1;
        end else if (event_s[2]) begin
          ld_sel_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
      end
      ST_ISSUE:   wait_clr_s = 1'b1;
      ST_CAPTURE: cap_s = 1'b1;
      default:    cap_s = 1'b0;
    endcase
  end

  // Operand, result and status registers that drive every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r        <= 4'd0;
      b_r        <= 4'd0;
      sel_r      <= 2'd0;
      res_r      <= 4'd0;
      flags_r    <= 4'd0;
      loaded_r   <= 3'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      if (ld_a_s) begin
        a_r         <= no;
        loaded_r[0] <= 1'b1;
      end
      if (ld_b_s) begin
        b_r         <= no;
        loaded_r[1] <= 1'b1;
      end
      if (ld_sel_s) begin
        sel_r       <= no[1:0];
        loaded_r[2] <= 1'b1;
      end
      if (cap_s) begin
        res_r   <= alu_res;
        flags_r <= alu_flags;
      end
      if (wait_clr_s) begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end else if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= cap_s;
      err_r  <= err_s;
    end
  end

  assign alu_a   = a_r;
  assign alu_b   = b_r;
  assign alu_sel = sel_r;
  assign res     = res_r;
  assign flags   = flags_r;
  assign loaded  = loaded_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign err     = err_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a registered one-cycle behavioural ALU.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push1 = 1'b0;
  logic       push2 = 1'b0;
  logic       push3 = 1'b0;
  logic       push4 = 1'b0;
  logic [3:0] no = 4'd0;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_res = 4'd0;
  logic [3:0] alu_flags = 4'd0;
  logic [3:0] res;
  logic [3:0] flags;
  logic [2:0] loaded;
  logic       busy;
  logic       done;
  logic       err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEBOUNCE_CYCLES(4), .ALU_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .push1(push1), .push2(push2), .push3(push3), .push4(push4),
    .no(no), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
    .alu_flags(alu_flags), .res(res), .flags(flags), .loaded(loaded), .busy(busy),
    .done(done), .err(err)
  );

  // Flags are {cout, cf, zf, sf}; cf is the carry for add and the borrow for sub.
  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] sel);
    logic [4:0] s;
    logic [3:0] r;
    logic       co;
    logic       cf;
    s = 5'd0; r = 4'd0; co = 1'b0; cf = 1'b0;
    case (sel)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; co = s[4]; cf = s[4]; end
      2'b01: begin r = a - b; cf = (a < b); end
      2'b10: r = a & b;
      2'b11: r = a | b;
      default: r = 4'd0;
    endcase
    return {r, co, cf, (r == 4'd0), r[3]};
  endfunction

  always @(posedge clk) {alu_res, alu_flags} <= alu_model(alu_a, alu_b, alu_sel);

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int btn, input logic v);
    case (btn)
      1: push1 = v;
      2: push2 = v;
      3: push3 = v;
      default: push4 = v;
    endcase
  endtask

  task automatic press(input int btn, input logic [3:0] val);
    no = val;
    set_btn(btn, 1'b1);
    cyc(10);
    set_btn(btn, 1'b0);
    cyc(8);
  endtask

  initial begin
    cyc(2);
    chk("rst_alu_a", 8'(alu_a), 8'd0);
    chk("rst_res_flags", {res, flags}, 8'd0);
    chk("rst_status", {2'd0, loaded, busy, done, err}, 8'd0);
    rst = 1'b0;
    cyc(2);

    // Test 1: load A with exact event timing, then B and sel, then add 3+5.
    no = 4'd3;
    push1 = 1'b1;
    cyc(6);
    chk("t1_a_not_yet", 8'(alu_a), 8'd0);
    cyc(1);
    chk("t1_a_loaded", 8'(alu_a), 8'd3);
    chk("t1_loaded_a", 8'(loaded), 8'd1);
    cyc(3);
    push1 = 1'b0;
    cyc(8);
    press(2, 4'd5);
    chk("t1_b_loaded", 8'(alu_b), 8'd5);
    chk("t1_loaded_ab", 8'(loaded), 8'd3);
    press(3, 4'd0);
    chk("t1_loaded_all", 8'(loaded), 8'd7);
    chk("t1_sel", 8'(alu_sel), 8'd0);
    push4 = 1'b1;
    cyc(6);
    chk("t1_busy_T", 8'(busy), 8'd0);
    cyc(1);
    chk("t1_busy_T1", {busy, done}, 8'd2);
    cyc(2);
    chk("t1_busy_T3", {busy, done}, 8'd2);
    cyc(1);
    chk("t1_done_T4", {busy, done, err}, 8'd2);
    chk("t1_res_flags", {res, flags}, 8'h81);
    cyc(1);
    chk("t1_done_once", 8'(done), 8'd0);
    chk("t1_res_hold", 8'(res), 8'd8);
    push4 = 1'b0;
    cyc(8);

    // Test 4: subtract; push2 with no=9 lands while busy and must be dropped.
    press(3, 4'd1);
    chk("t4_sel_sub", 8'(alu_sel), 8'd1);
    push4 = 1'b1;
    cyc(2);
    no = 4'd9;
    push2 = 1'b1;
    cyc(4);
    chk("t4_busy_T", 8'(busy), 8'd0);
    cyc(1);
    chk("t4_busy_T1", 8'(busy), 8'd1);
    cyc(1);
    chk("t4_busy_T2", {busy, err}, 8'd2);
    chk("t4_b_frozen", 8'(alu_b), 8'd5);
    cyc(1);
    chk("t4_busy_T3", {busy, done}, 8'd2);
    cyc(1);
    chk("t4_done_T4", {busy, done}, 8'd1);
    chk("t4_res_flags", {res, flags}, 8'hE5);
    cyc(1);
    push4 = 1'b0;
    push2 = 1'b0;
    cyc(8);
    chk("t4_b_unchanged", 8'(alu_b), 8'd5);

    // Test 5: push1 and push4 together; execute wins and the old A is used.
    press(3, 4'd0);
    no = 4'd7;
    push1 = 1'b1;
    push4 = 1'b1;
    cyc(6);
    chk("t5_busy_T", 8'(busy), 8'd0);
    cyc(1);
    chk("t5_busy_T1", 8'(busy), 8'd1);
    chk("t5_a_old", 8'(alu_a), 8'd3);
    cyc(3);
    chk("t5_done", 8'(done), 8'd1);
    chk("t5_res_flags", {res, flags}, 8'h81);
    push1 = 1'b0;
    push4 = 1'b0;
    cyc(8);
    chk("t5_a_kept", 8'(alu_a), 8'd3);

    // Test 2: bouncing push1, then held; one event six cycles after the final rise.
    no = 4'd10;
    for (int k = 0; k < 3; k++) begin
      push1 = 1'b1;
      cyc(2);
      push1 = 1'b0;
      cyc(2);
    end
    push1 = 1'b1;
    cyc(6);
    chk("t2_bounce_quiet", 8'(alu_a), 8'd3);
    cyc(1);
    chk("t2_event", 8'(alu_a), 8'd10);
    cyc(1);
    no = 4'd11;
    cyc(8);
    push1 = 1'b0;
    cyc(8);
    chk("t2_single_event", 8'(alu_a), 8'd10);
    no = 4'd12;
    push1 = 1'b1;
    cyc(3);
    push1 = 1'b0;
    cyc(10);
    chk("t2_glitch", 8'(alu_a), 8'd10);

    rst = 1'b1;
    cyc(1);
    chk("rst2_regs", {alu_a, alu_b}, 8'd0);
    chk("rst2_res_flags", {res, flags}, 8'd0);
    chk("rst2_status", {alu_sel, loaded, busy, done, err}, 8'd0);
    rst = 1'b0;
    cyc(2);

    // Test 3: execute with only A loaded is rejected.
    press(1, 4'd4);
    chk("t3_loaded_a", 8'(loaded), 8'd1);
    push4 = 1'b1;
    cyc(6);
    chk("t3_err_T", 8'(err), 8'd0);
    cyc(1);
    chk("t3_err_pulse", {busy, err}, 8'd1);
    cyc(1);
    chk("t3_err_gone", {busy, done, err}, 8'd0);
    chk("t3_res", 8'(res), 8'd0);
    push4 = 1'b0;
    cyc(8);

    // Test 6: reset during WAIT cancels the operation.
    press(2, 4'd6);
    press(3, 4'd0);
    chk("t6_loaded_all", 8'(loaded), 8'd7);
    push4 = 1'b1;
    cyc(8);
    chk("t6_busy_wait", 8'(busy), 8'd1);
    push4 = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_regs", {alu_a, alu_b}, 8'd0);
    chk("t6_rst_status", {alu_sel, loaded, busy, done, err}, 8'd0);
    chk("t6_rst_res", {res, flags}, 8'd0);
    cyc(1);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk("t6_no_done", {busy, done}, 8'd0);
    end
    chk("t6_loaded_clr", 8'(loaded), 8'd0);
    push4 = 1'b1;
    cyc(7);
    chk("t6_idle_err", 8'(err), 8'd1);
    push4 = 1'b0;
    cyc(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
